tff_updown_counter: RTL

- Synchronous WIDTH-bit up/down counter built from a chain of toggle-flip-flop cells.
- Each bit toggles when all lower bits are 1 (count up) or all 0 (count down), gated by enable.
- Consumes the toggle-cell primitive and produces a count plus a terminal-count strobe for downstream dividers and timers.
- Adds a synchronous reset and a parallel load.

---
 rtl/tff_updown_counter_pkg.sv | 28 ++
 rtl/tff_cell.sv | 37 +++
 rtl/tff_updown_counter.sv | 66 ++++++
 3 files changed

// File: rtl/tff_updown_counter_pkg.sv
// Shared constants and limit-compare helpers for the toggle-cell up/down counter.
package tff_updown_counter_pkg;

   localparam int   DEFAULT_WIDTH = 4;
   localparam int   MAX_WIDTH     = 16;
   localparam logic DIR_UP        = 1'b1;
   localparam logic DIR_DOWN      = 1'b0;

   // Bits at and above w are don't-care, so one helper serves every legal width.
   function automatic logic is_all_ones(input logic [MAX_WIDTH-1:0] v, input int w);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         r = r & (v[i] | (i >= w));
      end
      return r;
   endfunction

   function automatic logic is_zero(input logic [MAX_WIDTH-1:0] v, input int w);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         r = r & (~v[i] | (i >= w));
      end
      return r;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop cell with synchronous active-low reset and parallel load.
module tff_cell
   import tff_updown_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic t,
   input  logic ld,
   input  logic ld_val,
   output logic q
);

   logic bit_d;
   logic bit_q;

   // Next state: load beats toggle.
   always_comb begin
      bit_d = bit_q;
      if (ld) begin
         bit_d = ld_val;
      end else begin
         bit_d = bit_q ^ t;
      end
   end

   // State register; reset wins over load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign q = bit_q;

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit up/down counter built from a chain of tff_cell toggle cells.
// Define TFF_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module tff_updown_counter
   import tff_updown_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   logic [WIDTH-1:0]     q_s;
   logic [WIDTH-1:0]     t_s;
   logic [MAX_WIDTH-1:0] q_ext_s;
   logic                 at_ones_s;
   logic                 at_zero_s;
   logic                 at_limit_s;
   logic                 cnt_en_s;

   // Zero-extend the count so the package helpers can take any legal width.
   always_comb begin
      q_ext_s            = {MAX_WIDTH{1'b0}};
      q_ext_s[WIDTH-1:0] = q_s;
   end

   assign at_ones_s  = is_all_ones(q_ext_s, WIDTH);
   assign at_zero_s  = is_zero(q_ext_s, WIDTH);
   assign at_limit_s = (up == DIR_UP) ? at_ones_s : at_zero_s;
   assign tc         = en & at_limit_s;

   // Chain enable; saturation freezes every toggle at the limit.
   always_comb begin
`ifdef TFF_COUNTER_SAT_EN
      cnt_en_s = en & ~at_limit_s;
`else
      cnt_en_s = en;
`endif
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         assign t_s[i] = cnt_en_s;
      end else begin : g_upper
         assign t_s[i] = cnt_en_s & ((up == DIR_UP) ? (&q_s[i-1:0]) : (~|q_s[i-1:0]));
      end

      tff_cell u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .t      (t_s[i]),
         .ld     (load),
         .ld_val (d[i]),
         .q      (q_s[i])
      );
   end

   assign q = q_s;

endmodule
